fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8: width of all program-counter and address signals.
REQ-002 SHALL have parameter DEPTH, default 4: output-queue entries and maximum in-flight requests; power of two, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-007 SHALL have port imem_req_ready  input  1  instruction memory accepts the request.
REQ-008 SHALL have port imem_req_addr  output  PC_WIDTH  byte address of the requested word.
REQ-009 SHALL have port imem_resp_valid  input  1  one response word returned, in request order, with no backpressure.
REQ-010 SHALL have port imem_resp_data  input  32  returned instruction word.
REQ-011 SHALL have port inst_valid  output  1  instruction available to decode.
REQ-012 SHALL have port inst_ready  input  1  decode consumes the instruction.
REQ-013 SHALL have port inst_data  output  32  instruction word at the queue head.
REQ-014 SHALL have port inst_pc  output  PC_WIDTH  address of inst_data.
REQ-015 SHALL have port redirect_valid  input  1  branch taken, flush and refetch.
REQ-016 SHALL have port redirect_pc  input  PC_WIDTH  branch target address.

Function
REQ-017 SHALL hold fetch_pc; a request handshake (imem_req_valid and imem_req_ready) advances it by 4, wrapping modulo 2^PC_WIDTH (0xFC+4 gives 0x00 at the default width).
REQ-018 SHALL drive imem_req_addr = fetch_pc with bits [1:0] always zero, stable while imem_req_valid is high and imem_req_ready is low.
REQ-019 SHALL assert imem_req_valid only when not in reset, redirect_valid is low, and queue occupancy plus outstanding requests is below DEPTH (credit rule: the queue can never overflow).
REQ-020 SHALL record each accepted request address in an internal DEPTH-entry tag FIFO and pair it, in order, with the next non-discarded response.
REQ-021 SHALL push {imem_resp_data, tag} into the output queue on a non-discarded response; inst_valid rises on the next cycle (one-cycle response-to-decode latency).
REQ-022 SHALL present the queue head on inst_data/inst_pc and pop it on inst_valid and inst_ready; a simultaneous push and pop at full or empty occupancy is legal and keeps the count consistent.
REQ-023 SHALL handle redirect_valid as follows: empty the output queue and tag FIFO; load fetch_pc with redirect_pc with bits [1:0] cleared; set the discard counter to the post-cycle outstanding count; force inst_valid low combinationally in that cycle (no handshake occurs).
REQ-024 SHALL drop a response arriving while the discard counter is non-zero, decrementing both the discard and outstanding counters; a response in the redirect cycle itself is dropped.
REQ-025 SHALL treat a redirect while discards are pending as re-arming the counter with the total outstanding count.
REQ-026 SHALL issue the first request to the redirect target no earlier than the cycle after redirect_valid.
REQ-027 SHALL ignore imem_resp_valid when outstanding is zero (protocol error; no state change).

Reset
REQ-028 SHALL on reset set fetch_pc=RESET_PC, queue, tag FIFO, outstanding and discard counters to zero, and drive imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
REQ-029 SHALL let reset override every other input, including mid-flight responses and redirect, and SHALL drop responses to pre-reset requests that arrive afterwards only if the memory is reset with it (the memory is required to be reset together with this block).
REQ-030 SHALL raise imem_req_valid no earlier than the first cycle after reset deasserts.

Configuration
REQ-031 SHALL, with FETCH_PERF_EN defined, add outputs perf_fetched (32) counting instruction handshakes and perf_flushes (32) counting redirect cycles, both zeroed on reset and wrapping at 2^32.
REQ-032 SHALL, without FETCH_PERF_EN, omit those ports and counters entirely, with otherwise identical behaviour.

Verification
REQ-033 SHALL verify: reset, imem_req_ready=1, 2-cycle response latency, inst_ready=1 -> inst_pc sequence 0x00,0x04,0x08 with matching data, first inst_valid 4 cycles after reset release.
REQ-034 SHALL verify: inst_ready=0 forever -> exactly 4 requests (0x00 to 0x0C) issued, then imem_req_valid stays low; queue holds 4 entries.
REQ-035 SHALL verify: redirect_pc=0x43 with 3 outstanding -> next request address 0x40, 3 responses dropped, first delivered inst_pc=0x40.
REQ-036 SHALL verify: fetch_pc=0xFC at PC_WIDTH=8 -> next request 0x00.
REQ-037 SHALL verify: redirect in the same cycle as a response and inst_ready=1 -> no handshake, response dropped, queue empty next cycle.
REQ-038 SHALL verify: with FETCH_PERF_EN, 10 consumed instructions and 2 redirects -> perf_fetched=10, perf_flushes=2.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response, decode and redirect signals of the fetch unit
interface fetch_unit_if #(
    parameter int PC_WIDTH = 8
);
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [PC_WIDTH-1:0] imem_req_addr;
    logic                imem_resp_valid;
    logic [31:0]         imem_resp_data;
    logic                inst_valid;
    logic                inst_ready;
    logic [31:0]         inst_data;
    logic [PC_WIDTH-1:0] inst_pc;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetch with in-order tag FIFO, output queue and redirect flush;
// defining FETCH_PERF_EN adds perf_fetched/perf_flushes counters
module fetch_unit #(
    parameter int                  PC_WIDTH = 8,
    parameter int                  DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        reset,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushes,
`endif
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PC_WIDTH-1:0] ALIGN = ~PC_WIDTH'(3);
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [CW-1:0]       outstanding, discard, q_count, out_next;
    logic [CW:0]         credits_used;
    logic [AW-1:0]       q_wr, q_rd, t_wr, t_rd;
    logic [31:0]         q_data [DEPTH];
    logic [PC_WIDTH-1:0] q_pc [DEPTH];
    logic [PC_WIDTH-1:0] t_pc [DEPTH];
    logic                redirect, req_fire, resp_ok, push, pop;
    // credit check, handshakes and queue-head presentation
    always_comb begin
        redirect           = bus.redirect_valid;
        credits_used       = {1'b0, q_count} + {1'b0, outstanding};
        bus.imem_req_valid = !reset && !redirect && credits_used < (CW+1)'(DEPTH);
        bus.imem_req_addr  = fetch_pc & ALIGN;
        bus.inst_valid     = !reset && !redirect && q_count != '0;
        bus.inst_data      = q_count != '0 ? q_data[q_rd] : '0;
        bus.inst_pc        = q_count != '0 ? q_pc[q_rd] : '0;
        req_fire           = bus.imem_req_valid && bus.imem_req_ready;
        resp_ok            = bus.imem_resp_valid && outstanding != '0;
        push               = resp_ok && discard == '0 && !redirect;
        pop                = bus.inst_valid && bus.inst_ready;
        out_next           = outstanding + CW'(req_fire) - CW'(resp_ok);
    end
    // fetch PC, outstanding/discard counters and the request tag FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            t_wr        <= '0;
            t_rd        <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect) begin
                fetch_pc <= bus.redirect_pc & ALIGN;
                discard  <= out_next;
                t_wr     <= '0;
                t_rd     <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc   <= fetch_pc + PC_WIDTH'(4);
                    t_pc[t_wr] <= bus.imem_req_addr;
                    t_wr       <= t_wr + 1'b1;
                end
                if (resp_ok && discard != '0)
                    discard <= discard - 1'b1;
                if (push)
                    t_rd <= t_rd + 1'b1;
            end
        end
    end
    // output queue: push paired responses, pop on decode handshake, flush on redirect
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            q_wr    <= '0;
            q_rd    <= '0;
            q_count <= '0;
        end else begin
            if (push) begin
                q_data[q_wr] <= bus.imem_resp_data;
                q_pc[q_wr]   <= t_pc[t_rd];
                q_wr         <= q_wr + 1'b1;
            end
            if (pop)
                q_rd <= q_rd + 1'b1;
            q_count <= q_count + CW'(push) - CW'(pop);
        end
    end
`ifdef FETCH_PERF_EN
    // performance counters: decode handshakes and redirect cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(pop);
            perf_flushes <= perf_flushes + 32'(redirect);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit; perf counters checked when FETCH_PERF_EN is defined
module tb_fetch_unit;
    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;
    fetch_unit_if #(.PC_WIDTH(8)) bus();
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushes;
`endif
    fetch_unit #(.PC_WIDTH(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk(clk),
        .reset(reset),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_flushes(perf_flushes),
`endif
        .bus(bus)
    );
    int passed = 0;
    int total = 0;
    logic [7:0] exp_q[$];
    logic [7:0] req_log[$];
    logic       p_v[3];
    logic [7:0] p_a[3];
    function automatic logic [31:0] mk(input logic [7:0] a);
        return {8'hE1, a, ~a, 8'h5A};
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask
    assign bus.imem_resp_valid = p_v[2];
    assign bus.imem_resp_data  = mk(p_a[2]);
    // instruction memory: response two cycles after the accepting edge, reset together with the DUT
    always @(posedge clk) begin
        if (reset) begin
            p_v[0] <= 0;
            p_v[1] <= 0;
            p_v[2] <= 0;
        end else begin
            p_v[0] <= bus.imem_req_valid && bus.imem_req_ready;
            p_a[0] <= bus.imem_req_addr;
            p_v[1] <= p_v[0];
            p_a[1] <= p_a[0];
            p_v[2] <= p_v[1];
            p_a[2] <= p_a[1];
        end
    end
    // monitor: log accepted requests and score every decode handshake against the expected queue
    always @(negedge clk) begin
        if (!reset && bus.imem_req_valid && bus.imem_req_ready)
            req_log.push_back(bus.imem_req_addr);
        if (!reset && bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_inst: got pc %h, expected no instruction", bus.inst_pc);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                check("inst_pc", bus.inst_pc, e);
                check("inst_data", bus.inst_data, mk(e));
            end
        end
    end
    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1;
        bus.redirect_valid = 0;
        @(posedge clk);
        #1;
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_inst_data", bus.inst_data, 0);
        check("rst_inst_pc", bus.inst_pc, 0);
        req_log.delete();
        exp_q.delete();
        @(posedge clk);
        #1 reset = 0;
    endtask
    task automatic drain(input int bound, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1 bus.inst_ready = 0;
        check("drain_done", exp_q.size(), 0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int first, n;
        bus.imem_req_ready = 0;
        bus.inst_ready     = 0;
        bus.redirect_valid = 0;
        bus.redirect_pc    = 0;
        // sequential fetch, 2-cycle memory, first instruction in cycle 4 after release
        bus.imem_req_ready = 1;
        bus.inst_ready     = 1;
        do_reset();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h08);
        first = 0;
        for (int c = 1; c <= 10 && first == 0; c++) begin
            @(posedge clk);
            #1;
            if (bus.inst_valid) first = c;
        end
        check("t1_first_valid_cycle", first, 4);
        drain(10, n);
        check("t1_req0", req_log[0], 8'h00);
        check("t1_req1", req_log[1], 8'h04);
        check("t1_req2", req_log[2], 8'h08);
        // decode stalled: credits stop fetch at four requests, queue holds four
        bus.inst_ready = 0;
        do_reset();
        repeat (20) @(posedge clk);
        #1;
        check("t2_req_count", req_log.size(), 4);
        check("t2_last_req", req_log[3], 8'h0C);
        check("t2_req_valid_low", bus.imem_req_valid, 0);
        check("t2_inst_valid", bus.inst_valid, 1);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(i * 4));
        bus.inst_ready = 1;
        drain(10, n);
        check("t2_pop_cycles", n, 4);
        // redirect to 0x43 with three requests outstanding
        bus.imem_req_ready = 1;
        bus.inst_ready     = 1;
        do_reset();
        repeat (3) @(posedge clk);
        #1 bus.redirect_valid = 1;
        bus.redirect_pc = 8'h43;
        check("t3_outstanding_reqs", req_log.size(), 3);
        @(negedge clk);
        check("t3_no_req_in_redirect", bus.imem_req_valid, 0);
        @(posedge clk);
        #1 bus.redirect_valid = 0;
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h48);
        drain(20, n);
        check("t3_first_new_req", req_log[3], 8'h40);
        // address wrap 0xFC -> 0x00 (target 0xFA aligns to 0xF8)
        bus.imem_req_ready = 0;
        bus.inst_ready     = 0;
        do_reset();
        @(posedge clk);
        #1 bus.redirect_valid = 1;
        bus.redirect_pc = 8'hFA;
        @(posedge clk);
        #1 bus.redirect_valid = 0;
        bus.imem_req_ready = 1;
        bus.inst_ready     = 1;
        exp_q.push_back(8'hF8);
        exp_q.push_back(8'hFC);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h04);
        drain(20, n);
        check("t4_req_f8", req_log[0], 8'hF8);
        check("t4_req_fc", req_log[1], 8'hFC);
        check("t4_req_wrap", req_log[2], 8'h00);
        // redirect coinciding with a response while decode is ready
        bus.imem_req_ready = 1;
        bus.inst_ready     = 0;
        do_reset();
        repeat (2) @(posedge clk);
        #1 bus.imem_req_ready = 0;
        repeat (2) @(posedge clk);
        #1 bus.redirect_valid = 1;
        bus.redirect_pc = 8'h80;
        bus.inst_ready  = 1;
        @(negedge clk);
        check("t5_inst_valid_forced_low", bus.inst_valid, 0);
        @(posedge clk);
        #1 bus.redirect_valid = 0;
        bus.inst_ready = 0;
        check("t5_queue_empty", bus.inst_valid, 0);
        bus.imem_req_ready = 1;
        bus.inst_ready     = 1;
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h84);
        drain(20, n);
`ifdef FETCH_PERF_EN
        // ten consumed instructions and two redirects
        bus.imem_req_ready = 1;
        bus.inst_ready     = 1;
        do_reset();
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(i * 4));
        drain(40, n);
        repeat (2) begin
            @(posedge clk);
            #1 bus.redirect_valid = 1;
            bus.redirect_pc = 8'h20;
            @(posedge clk);
            #1 bus.redirect_valid = 0;
        end
        @(posedge clk);
        #1;
        check("t6_perf_fetched", perf_fetched, 10);
        check("t6_perf_flushes", perf_flushes, 2);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
